// File: rtl/lo_sync_pkg.sv
// rtl/lo_sync_pkg.sv - shared types and defaults for the LO phase sync controller
// Contents: FSM state enum, {I,Q} quadrant type, default parameter values.
package lo_sync_pkg;

  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_SAMP_CYC   = 64;
  localparam int DEF_MAX_ITER   = 8;

  typedef logic [1:0] quad_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETDIV,
    S_SETTLE,
    S_SAMPLE,
    S_DECIDE,
    S_SLIPST,
    S_LOCK,
    S_FAIL
  } sync_state_e;

endpackage

// File: rtl/lo_state_hist.sv
// rtl/lo_state_hist.sv - four-bin LO_STATE histogram with argmax
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : zero all bins (wins over en)
//   en           : count lo_state into its bin this cycle
//   lo_state     : sampled {I,Q} quadrant
//   dom, dom_cnt : index and count of the fullest bin (lowest index on ties)
module lo_state_hist
  import lo_sync_pkg::*;
#(
  parameter int SAMP_CYC = DEF_SAMP_CYC,
  localparam int BIN_W   = $clog2(SAMP_CYC) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       lo_state,
  output logic [1:0]       dom,
  output logic [BIN_W-1:0] dom_cnt
);

  logic [3:0][BIN_W-1:0] bin_q, bin_d;

  always_comb begin
    bin_d = bin_q;
    if (clr) begin
      bin_d = '0;
    end else if (en && (bin_q[lo_state] != {BIN_W{1'b1}})) begin
      bin_d[lo_state] = bin_q[lo_state] + 1'b1;
    end
  end

  // Strict greater-than keeps the earlier (lower) index on ties.
  always_comb begin
    dom     = '0;
    dom_cnt = bin_q[0];
    for (int i = 1; i < 4; i++) begin
      if (bin_q[i] > dom_cnt) begin
        dom     = 2'(i);
        dom_cnt = bin_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bin_q <= '0;
    else        bin_q <= bin_d;
  end

endmodule

// File: rtl/lo_phase_sync_ctrl.sv
// rtl/lo_phase_sync_ctrl.sv - LO divider phase alignment controller
// Ports:
//   REF, NRST           : clock, asynchronous active-low reset
//   START, ABORT        : begin a sync sequence / cancel it
//   DIV_CFG, TARGET_STATE : divider code and wanted quadrant, captured at start
//   LO_STATE            : sampled {I,Q} from the LO generator
//   LO_DIV, SLIP        : divider code and edge-swallow pulse to the LO generator
//   BUSY, LOCKED, FAIL, ITER : status and SLIP count of the current sequence
module lo_phase_sync_ctrl
  import lo_sync_pkg::*;
#(
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int SAMP_CYC   = DEF_SAMP_CYC,
  parameter int MAX_ITER   = DEF_MAX_ITER
) (
  input  logic       REF,
  input  logic       NRST,
  input  logic       START,
  input  logic       ABORT,
  input  logic [2:0] DIV_CFG,
  input  logic [1:0] TARGET_STATE,
  input  logic [1:0] LO_STATE,
  output logic [2:0] LO_DIV,
  output logic       SLIP,
  output logic       BUSY,
  output logic       LOCKED,
  output logic       FAIL,
  output logic [3:0] ITER
);

  localparam int CNT_MAX = (SETTLE_CYC > SAMP_CYC) ? SETTLE_CYC : SAMP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIN_W   = $clog2(SAMP_CYC) + 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'(SAMP_CYC - 1);
  localparam logic [BIN_W-1:0] LOCK_THR    = BIN_W'((3 * SAMP_CYC) / 4);
  localparam logic [3:0]       ITER_LIM    = 4'(MAX_ITER);

  sync_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       div_q, div_d;
  quad_t            tgt_q, tgt_d;
  logic [2:0]       lo_div_q, lo_div_d;
  logic [3:0]       iter_q, iter_d;
  logic             slip_q, slip_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;

  logic             hist_clr, hist_en;
  quad_t            dom;
  logic [BIN_W-1:0] dom_cnt;

  lo_state_hist #(.SAMP_CYC(SAMP_CYC)) u_hist (
    .clk      (REF),
    .rst_n    (NRST),
    .clr      (hist_clr),
    .en       (hist_en),
    .lo_state (LO_STATE),
    .dom      (dom),
    .dom_cnt  (dom_cnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    tgt_d    = tgt_q;
    lo_div_d = lo_div_q;
    iter_d   = iter_q;
    slip_d   = 1'b0;

    if (ABORT) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_LOCK, S_FAIL: begin
          if (START) begin
            state_d = S_SETDIV;
            div_d   = DIV_CFG;
            tgt_d   = TARGET_STATE;
            iter_d  = '0;
          end
        end
        S_SETDIV: begin
          lo_div_d = div_q;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (cnt_q == SAMP_LAST) begin
            cnt_d   = '0;
            state_d = S_DECIDE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DECIDE: begin
          // dom == target already implies dom_cnt is the target bin.
          if ((dom == tgt_q) && (dom_cnt >= LOCK_THR)) begin
            state_d = S_LOCK;
          end else if (iter_q == ITER_LIM) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_SLIPST;
            slip_d  = 1'b1;
            iter_d  = iter_q + 4'd1;
          end
        end
        S_SLIPST: begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d   = !((state_d == S_IDLE) || (state_d == S_LOCK) || (state_d == S_FAIL));
    locked_d = (state_d == S_LOCK);
    fail_d   = (state_d == S_FAIL);
  end

  // Bins are zeroed on the edge that enters SAMPLE, then count every SAMPLE cycle.
  assign hist_clr = (state_q == S_SETTLE) && (state_d == S_SAMPLE);
  assign hist_en  = (state_q == S_SAMPLE);

  always_ff @(posedge REF or negedge NRST) begin
    if (!NRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      tgt_q    <= '0;
      lo_div_q <= '0;
      iter_q   <= '0;
      slip_q   <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      tgt_q    <= tgt_d;
      lo_div_q <= lo_div_d;
      iter_q   <= iter_d;
      slip_q   <= slip_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
    end
  end

  assign LO_DIV = lo_div_q;
  assign SLIP   = slip_q;
  assign BUSY   = busy_q;
  assign LOCKED = locked_q;
  assign FAIL   = fail_q;
  assign ITER   = iter_q;

endmodule

// File: tb/tb_lo_phase_sync_ctrl.sv
// tb/tb_lo_phase_sync_ctrl.sv - self-checking bench for lo_phase_sync_ctrl
module tb_lo_phase_sync_ctrl;

  localparam int ROUND = 1 + 16 + 64 + 1;

  logic       REF = 1'b0;
  logic       NRST, START, ABORT;
  logic [2:0] DIV_CFG;
  logic [1:0] TARGET_STATE, LO_STATE;
  logic [2:0] LO_DIV;
  logic       SLIP, BUSY, LOCKED, FAIL;
  logic [3:0] ITER;

  int checks = 0;
  int passed = 0;

  // LO generator stimulus: one 64-entry pattern per SLIP count, replayed cyclically.
  logic [1:0] pat [9][64];
  int         phase = 0;
  int         cyc = 0;
  logic [2:0] lo_div_exp = 3'd0;

  lo_phase_sync_ctrl dut (
    .REF(REF), .NRST(NRST), .START(START), .ABORT(ABORT),
    .DIV_CFG(DIV_CFG), .TARGET_STATE(TARGET_STATE), .LO_STATE(LO_STATE),
    .LO_DIV(LO_DIV), .SLIP(SLIP), .BUSY(BUSY), .LOCKED(LOCKED),
    .FAIL(FAIL), .ITER(ITER)
  );

  always #5 REF = ~REF;

  task automatic drive_lo();
    LO_STATE = pat[(phase > 8) ? 8 : phase][cyc % 64];
    cyc++;
  endtask

  task automatic fill_const(input int p, input logic [1:0] v);
    for (int j = 0; j < 64; j++) pat[p][j] = v;
  endtask

  // n entries of t, the rest spread evenly over the other three quadrants
  task automatic fill_mix(input int p, input logic [1:0] t, input int n);
    logic [1:0] o;
    for (int j = 0; j < 64; j++) begin
      o = t + 2'(1 + (j % 3));
      pat[p][j] = (j < n) ? t : o;
    end
  endtask

  task automatic fill_rand(input int p, input logic [1:0] t);
    int n;
    logic [1:0] o;
    n = $urandom_range(20, 64);
    for (int j = 0; j < 64; j++) begin
      o = t + 2'($urandom_range(1, 3));
      pat[p][j] = (j < n) ? t : o;
    end
  endtask

  // Reference: per iteration count quadrants, pick the fullest (lowest on ties),
  // lock when it is the target at >= 3/4 of the window, fail after 8 slips.
  task automatic predict(input logic [1:0] tgt, output int k, output bit lock);
    int cnt[4];
    int dom;
    bit done;
    k = 8;
    lock = 1'b0;
    done = 1'b0;
    for (int it = 0; it <= 8; it++) begin
      if (!done) begin
        cnt = '{0, 0, 0, 0};
        for (int j = 0; j < 64; j++) cnt[pat[it][j]]++;
        dom = 0;
        for (int q = 1; q < 4; q++) if (cnt[q] > cnt[dom]) dom = q;
        if (dom == int'(tgt) && cnt[dom] * 4 >= 3 * 64) begin
          k = it;
          lock = 1'b1;
          done = 1'b1;
        end
      end
    end
  endtask

  // Starts at a negedge; observes each cycle up to one cycle past the outcome.
  task automatic run_seq(input string name, input logic [2:0] div,
                         input logic [1:0] tgt, input bit noisy);
    int k, end_i, exp_iter;
    bit lock, exp_busy, exp_slip, exp_lock, exp_fail;
    logic [2:0] exp_div;
    predict(tgt, k, lock);
    end_i = ROUND * (k + 1);
    START = 1'b1;
    DIV_CFG = div;
    TARGET_STATE = tgt;
    phase = 0;
    drive_lo();
    for (int i = 0; i <= end_i + 1; i++) begin
      @(negedge REF);
      exp_busy = (i < end_i);
      exp_iter = (i / ROUND < k) ? i / ROUND : k;
      exp_slip = (i > 0) && (i % ROUND == 0) && (i < end_i);
      exp_lock = (i >= end_i) && lock;
      exp_fail = (i >= end_i) && !lock;
      exp_div  = (i == 0) ? lo_div_exp : div;
      checks++;
      if (BUSY !== exp_busy) $display("FAIL %s busy @%0d: got %b want %b", name, i, BUSY, exp_busy);
      else passed++;
      checks++;
      if (SLIP !== exp_slip) $display("FAIL %s slip @%0d: got %b want %b", name, i, SLIP, exp_slip);
      else passed++;
      checks++;
      if (ITER !== 4'(exp_iter)) $display("FAIL %s iter @%0d: got %0d want %0d", name, i, ITER, exp_iter);
      else passed++;
      checks++;
      if (LO_DIV !== exp_div) $display("FAIL %s lo_div @%0d: got %0d want %0d", name, i, LO_DIV, exp_div);
      else passed++;
      checks++;
      if ({LOCKED, FAIL} !== {exp_lock, exp_fail})
        $display("FAIL %s locked/fail @%0d: got %b%b want %b%b", name, i, LOCKED, FAIL, exp_lock, exp_fail);
      else passed++;
      if (SLIP) phase++;
      drive_lo();
      START = 1'b0;
      if (noisy && i < end_i) begin
        START = 1'($urandom_range(0, 1));
        DIV_CFG = 3'($urandom);
        TARGET_STATE = 2'($urandom);
      end
    end
    lo_div_exp = div;
  endtask

  task automatic test_reset();
    NRST = 1'b1;
    #2 NRST = 1'b0;
    #1;
    checks++;
    if ({LO_DIV, SLIP, BUSY, LOCKED, FAIL, ITER} !== 12'd0)
      $display("FAIL reset_init: got %h want 0", {LO_DIV, SLIP, BUSY, LOCKED, FAIL, ITER});
    else passed++;
    repeat (2) @(negedge REF);
    NRST = 1'b1;
    // start a sequence and reset it in the middle of SAMPLE
    fill_const(0, 2'b01);
    phase = 0;
    START = 1'b1; DIV_CFG = 3'd5; TARGET_STATE = 2'b11;
    drive_lo();
    @(negedge REF);
    START = 1'b0;
    repeat (40) begin
      @(negedge REF);
      drive_lo();
    end
    checks++;
    if ({BUSY, LO_DIV} !== {1'b1, 3'd5}) $display("FAIL pre_reset busy/div: got %b/%0d want 1/5", BUSY, LO_DIV);
    else passed++;
    #2 NRST = 1'b0;
    #1;
    checks++;
    if ({LO_DIV, SLIP, BUSY, LOCKED, FAIL, ITER} !== 12'd0)
      $display("FAIL reset_mid_sample: got %h want 0", {LO_DIV, SLIP, BUSY, LOCKED, FAIL, ITER});
    else passed++;
    repeat (3) @(negedge REF);
    NRST = 1'b1;
    repeat (6) @(negedge REF);
    checks++;
    if ({LO_DIV, SLIP, BUSY, LOCKED, FAIL, ITER} !== 12'd0)
      $display("FAIL reset_idle_after: got %h want 0", {LO_DIV, SLIP, BUSY, LOCKED, FAIL, ITER});
    else passed++;
    lo_div_exp = 3'd0;
  endtask

  task automatic test_immediate_lock();
    for (int p = 0; p < 9; p++) fill_const(p, 2'b10);
    run_seq("immediate_lock", 3'd4, 2'b10, 1'b0);
  endtask

  task automatic test_slip_convergence();
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int p = 0; p < 9; p++) fill_const(p, seq[p % 4]);
    run_seq("slip_converge", 3'd2, 2'b11, 1'b1);
  endtask

  task automatic test_failure();
    for (int p = 0; p < 9; p++) fill_const(p, 2'b01);
    run_seq("failure", 3'd7, 2'b00, 1'b1);
  endtask

  task automatic test_weak_majority();
    fill_mix(0, 2'b01, 40);
    for (int p = 1; p < 9; p++) fill_const(p, 2'b01);
    run_seq("weak_majority", 3'd1, 2'b01, 1'b0);
  endtask

  task automatic test_threshold();
    for (int p = 0; p < 9; p++) fill_mix(p, 2'b11, 48);
    run_seq("thr_48", 3'd3, 2'b11, 1'b0);
    fill_mix(0, 2'b00, 47);
    for (int p = 1; p < 9; p++) fill_mix(p, 2'b00, 48);
    run_seq("thr_47", 3'd6, 2'b00, 1'b0);
  endtask

  task automatic test_abort();
    for (int p = 0; p < 9; p++) fill_const(p, 2'b10);
    // ABORT together with START out of LOCK: ABORT wins
    run_seq("pre_abort_lock", 3'd0, 2'b10, 1'b0);
    ABORT = 1'b1; START = 1'b1;
    @(negedge REF);
    ABORT = 1'b0; START = 1'b0;
    checks++;
    if ({BUSY, LOCKED, FAIL} !== 3'b000) $display("FAIL abort_from_lock: got %b want 000", {BUSY, LOCKED, FAIL});
    else passed++;
    // ABORT in SETTLE with START held while busy
    START = 1'b1; DIV_CFG = 3'd6; TARGET_STATE = 2'b10;
    @(negedge REF);
    START = 1'b0;
    @(negedge REF);
    START = 1'b1;
    repeat (3) @(negedge REF);
    checks++;
    if ({BUSY, LO_DIV} !== {1'b1, 3'd6}) $display("FAIL abort_pre_busy: got %b/%0d want 1/6", BUSY, LO_DIV);
    else passed++;
    ABORT = 1'b1;
    @(negedge REF);
    ABORT = 1'b0; START = 1'b0;
    checks++;
    if ({BUSY, SLIP, LOCKED, FAIL, ITER} !== 8'd0) $display("FAIL abort_settle: got %h want 0", {BUSY, SLIP, LOCKED, FAIL, ITER});
    else passed++;
    checks++;
    if (LO_DIV !== 3'd6) $display("FAIL abort_lo_div_kept: got %0d want 6", LO_DIV);
    else passed++;
    for (int i = 0; i < 100; i++) begin
      @(negedge REF);
      checks++;
      if ({BUSY, SLIP} !== 2'b00) $display("FAIL abort_stays_idle @%0d: got %b want 00", i, {BUSY, SLIP});
      else passed++;
    end
    lo_div_exp = 3'd6;
  endtask

  task automatic test_back_to_back();
    logic [1:0] t;
    for (int s = 0; s < 6; s++) begin
      t = 2'($urandom);
      for (int p = 0; p < 9; p++) fill_rand(p, t);
      run_seq($sformatf("random_%0d", s), 3'($urandom), t, 1'b1);
    end
  endtask

  initial begin
    START = 1'b0; ABORT = 1'b0; DIV_CFG = 3'd0; TARGET_STATE = 2'd0; LO_STATE = 2'd0;
    test_reset();
    test_immediate_lock();
    test_slip_convergence();
    test_failure();
    test_weak_majority();
    test_threshold();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
